// File: rtl/instr_buffer_if.sv
// Decode-to-scoreboard handshake bundle for instr_buffer: decode push side,
// presented-instruction side and the next-cycle lookahead fields.
interface instr_buffer_if #(
    parameter int NUM_WARPS = 4,
    parameter int NUM_REGS  = 32,
    parameter int UUID_W    = 44,
    parameter int DATA_W    = 64
);
    localparam int WID_W = $clog2(NUM_WARPS);
    localparam int RW    = $clog2(NUM_REGS);

    logic              dec_valid;
    logic              dec_ready;
    logic [WID_W-1:0]  dec_wid;
    logic [31:0]       dec_pc;
    logic              dec_wb;
    logic [RW-1:0]     dec_rd, dec_rs1, dec_rs2, dec_rs3;
    logic [UUID_W-1:0] dec_uuid;
    logic [DATA_W-1:0] dec_data;

    logic              out_valid;
    logic              out_ready;
    logic [WID_W-1:0]  out_wid;
    logic [31:0]       out_pc;
    logic              out_wb;
    logic [RW-1:0]     out_rd, out_rs1, out_rs2, out_rs3;
    logic [UUID_W-1:0] out_uuid;
    logic [DATA_W-1:0] out_data;

    logic [WID_W-1:0]  out_wid_n;
    logic [RW-1:0]     out_rd_n, out_rs1_n, out_rs2_n, out_rs3_n;

    modport slave (
        input  dec_valid, dec_wid, dec_pc, dec_wb, dec_rd, dec_rs1, dec_rs2, dec_rs3,
               dec_uuid, dec_data, out_ready,
        output dec_ready, out_valid, out_wid, out_pc, out_wb, out_rd, out_rs1, out_rs2,
               out_rs3, out_uuid, out_data, out_wid_n, out_rd_n, out_rs1_n, out_rs2_n, out_rs3_n
    );

    modport master (
        output dec_valid, dec_wid, dec_pc, dec_wb, dec_rd, dec_rs1, dec_rs2, dec_rs3,
               dec_uuid, dec_data, out_ready,
        input  dec_ready, out_valid, out_wid, out_pc, out_wb, out_rd, out_rs1, out_rs2,
               out_rs3, out_uuid, out_data, out_wid_n, out_rd_n, out_rs1_n, out_rs2_n, out_rs3_n
    );
endinterface

// File: rtl/instr_buffer.sv
// Per-warp decoded-instruction FIFOs with round-robin issue into one registered slot.
// Optional stall counter enabled by defining IBUF_PERF_EN.
module instr_buffer #(
    parameter int NUM_WARPS = 4,
    parameter int IBUF_SIZE = 2,
    parameter int NUM_REGS  = 32,
    parameter int UUID_W    = 44,
    parameter int DATA_W    = 64
) (
    input  logic           clk,
    input  logic           reset,
    instr_buffer_if.slave  bus,
    output logic [31:0]    perf_stalls
);
    localparam int WID_W = $clog2(NUM_WARPS);
    localparam int PTR_W = $clog2(IBUF_SIZE);
    localparam int CNT_W = PTR_W + 1;
    localparam int RW    = $clog2(NUM_REGS);

    typedef struct packed {
        logic [31:0]       pc;
        logic              wb;
        logic [RW-1:0]     rd;
        logic [RW-1:0]     rs1;
        logic [RW-1:0]     rs2;
        logic [RW-1:0]     rs3;
        logic [UUID_W-1:0] uuid;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t           mem_r    [NUM_WARPS][IBUF_SIZE];
    logic [PTR_W-1:0] rd_ptr_r [NUM_WARPS];
    logic [PTR_W-1:0] wr_ptr_r [NUM_WARPS];
    logic [CNT_W-1:0] count_r  [NUM_WARPS];
    logic [WID_W-1:0] rr_r;
    logic [WID_W-1:0] out_wid_r;
    logic             out_valid_r;
    entry_t           out_ent_r;

    entry_t               dec_ent_s, cand_ent_s, next_ent_s;
    logic [WID_W-1:0]     cand_wid_s, idx_s, next_wid_s;
    logic                 found_s, enq_s, load_s, slot_load_s, bypass_s, push_s, next_valid_s;
    logic [NUM_WARPS-1:0] pop_s, push_vec_s;

    assign dec_ent_s = '{pc: bus.dec_pc, wb: bus.dec_wb, rd: bus.dec_rd, rs1: bus.dec_rs1,
                         rs2: bus.dec_rs2, rs3: bus.dec_rs3, uuid: bus.dec_uuid, data: bus.dec_data};

    // Acceptance looks only at the registered count, so a pop never frees room in the same cycle.
    assign bus.dec_ready = reset & (count_r[bus.dec_wid] != CNT_W'(IBUF_SIZE));
    assign enq_s         = bus.dec_valid & bus.dec_ready;
    assign load_s        = ~out_valid_r | bus.out_ready;

    // Round-robin search: first nonempty warp starting just after the last issued one.
    always_comb begin
        found_s    = 1'b0;
        cand_wid_s = '0;
        idx_s      = '0;
        for (int k = 1; k <= NUM_WARPS; k++) begin
            idx_s = rr_r + WID_W'(k);
            if (!found_s && (count_r[idx_s] != '0)) begin
                found_s    = 1'b1;
                cand_wid_s = idx_s;
            end else begin
                found_s    = found_s;
            end
        end
    end

    assign cand_ent_s = mem_r[cand_wid_s][rd_ptr_r[cand_wid_s]];

    // Next slot contents: queued candidate first, then bypass of the incoming push, else drain.
    always_comb begin
        bypass_s     = 1'b0;
        slot_load_s  = 1'b0;
        pop_s        = '0;
        next_valid_s = out_valid_r;
        next_ent_s   = out_ent_r;
        next_wid_s   = out_wid_r;
        if (load_s) begin
            if (found_s) begin
                slot_load_s         = 1'b1;
                next_valid_s        = 1'b1;
                next_ent_s          = cand_ent_s;
                next_wid_s          = cand_wid_s;
                pop_s[cand_wid_s]   = 1'b1;
            end else if (enq_s) begin
                slot_load_s  = 1'b1;
                bypass_s     = 1'b1;
                next_valid_s = 1'b1;
                next_ent_s   = dec_ent_s;
                next_wid_s   = bus.dec_wid;
            end else begin
                next_valid_s = 1'b0;
            end
        end else begin
            next_valid_s = out_valid_r;
        end
    end

    assign push_s     = enq_s & ~bypass_s;
    assign push_vec_s = push_s ? (NUM_WARPS'(1) << bus.dec_wid) : '0;

    // FIFO bookkeeping: pointers wrap naturally, count tracks push minus pop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                rd_ptr_r[w] <= '0;
                wr_ptr_r[w] <= '0;
                count_r[w]  <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (push_vec_s[w]) wr_ptr_r[w] <= wr_ptr_r[w] + PTR_W'(1);
                if (pop_s[w])      rd_ptr_r[w] <= rd_ptr_r[w] + PTR_W'(1);
                count_r[w] <= count_r[w] + CNT_W'(push_vec_s[w]) - CNT_W'(pop_s[w]);
            end
        end
    end

    // Entry storage; contents are only meaningful below the count, so no reset needed.
    always_ff @(posedge clk) begin
        if (push_s) mem_r[bus.dec_wid][wr_ptr_r[bus.dec_wid]] <= dec_ent_s;
    end

    // Output slot and round-robin pointer, which moves only when the slot is loaded.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid_r <= 1'b0;
            out_ent_r   <= '0;
            out_wid_r   <= '0;
            rr_r        <= '0;
        end else begin
            out_valid_r <= next_valid_s;
            out_ent_r   <= next_ent_s;
            out_wid_r   <= next_wid_s;
            if (slot_load_s) rr_r <= next_wid_s;
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_wid   = out_wid_r;
    assign bus.out_pc    = out_ent_r.pc;
    assign bus.out_wb    = out_ent_r.wb;
    assign bus.out_rd    = out_ent_r.rd;
    assign bus.out_rs1   = out_ent_r.rs1;
    assign bus.out_rs2   = out_ent_r.rs2;
    assign bus.out_rs3   = out_ent_r.rs3;
    assign bus.out_uuid  = out_ent_r.uuid;
    assign bus.out_data  = out_ent_r.data;

    // Lookahead is zero under reset so it still matches the slot one edge later.
    assign bus.out_wid_n = reset ? next_wid_s     : '0;
    assign bus.out_rd_n  = reset ? next_ent_s.rd  : '0;
    assign bus.out_rs1_n = reset ? next_ent_s.rs1 : '0;
    assign bus.out_rs2_n = reset ? next_ent_s.rs2 : '0;
    assign bus.out_rs3_n = reset ? next_ent_s.rs3 : '0;

`ifdef IBUF_PERF_EN
    logic [31:0] stalls_r;

    // Saturating count of cycles where a presented instruction is held back.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stalls_r <= 32'd0;
        end else if (out_valid_r && !bus.out_ready && (stalls_r != 32'hFFFF_FFFF)) begin
            stalls_r <= stalls_r + 32'd1;
        end
    end

    assign perf_stalls = stalls_r;
`else
    assign perf_stalls = 32'd0;
`endif
endmodule

// File: doc/instr_buffer.md
Name: instr_buffer

Overview:
- Per-warp decoded-instruction buffer between the decode stage and the scoreboard.
- Accepts one decoded instruction per cycle into a per-warp FIFO.
- Selects a ready warp round-robin and presents one registered instruction per cycle to the scoreboard.
- Also drives lookahead fields (*_n) that equal the presented instruction one cycle later, so the scoreboard can do a registered in-use lookup with no bubble.

Parameters:
- NUM_WARPS, 4, number of warps; power of 2, ≥2.
- IBUF_SIZE, 2, entries per warp FIFO; power of 2, ≥2.
- NUM_REGS, 32, architectural registers per warp.
- UUID_W, 44, instruction uuid width.
- DATA_W, 64, opaque payload width (ALU op, immediates, thread mask); passed through unchanged.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- dec_valid  in  1  decode instruction valid
- dec_ready  out  1  buffer can accept for dec_wid
- dec_wid  in  log2(NUM_WARPS)  warp id
- dec_pc  in  32  PC
- dec_wb  in  1  writes rd
- dec_rd / dec_rs1 / dec_rs2 / dec_rs3  in  log2(NUM_REGS) each  register ids
- dec_uuid  in  UUID_W  uuid
- dec_data  in  DATA_W  payload
- out_valid  out  1  instruction presented
- out_ready  in  1  scoreboard accepts
- out_wid, out_pc, out_wb, out_rd, out_rs1, out_rs2, out_rs3, out_uuid, out_data  out  same widths as dec_*
- out_wid_n, out_rd_n, out_rs1_n, out_rs2_n, out_rs3_n  out  same widths  next-cycle values of out_wid/out_rd/out_rs*
- perf_stalls  out  32  stall-cycle counter (see Optional Feature)

Behaviour:
- Reset is synchronous, active-low: sampled on the clk edge while reset==0.
  - All FIFO counts, pointers, out_valid, out_* fields, *_n fields and perf_stalls go to 0.
  - Round-robin pointer goes to warp 0.
  - dec_ready is 0 while reset is asserted.
- Enqueue fires on dec_valid & dec_ready. dec_ready = ~full[dec_wid], from registered count only; no same-cycle dequeue credit.
- Per-warp FIFO: circular, with rd/wr pointers of log2(IBUF_SIZE) bits that wrap naturally, and a count of log2(IBUF_SIZE)+1 bits.
- Output slot is a single register; out_* change only on the clock edge.
- Output slot is loadable when ~out_valid or (out_valid & out_ready).
- When loadable, the source is chosen as follows:
  1. First nonempty warp FIFO, searching circularly from (last issued wid + 1). That warp's head is popped into the slot.
  2. If all FIFOs are empty and an enqueue fires this cycle, bypass: the incoming instruction loads the slot directly and its FIFO is unchanged.
  3. Otherwise out_valid becomes 0.
- When not loadable, the slot holds and the FIFOs are not popped.
- *_n fields are the combinational next value of the slot: selected candidate if loadable and a candidate exists, else current out_* values. Invariant: out_rd (cycle t+1) == out_rd_n (cycle t), and likewise for the other *_n fields.
- Latency:
  - Empty buffer: dec fire at cycle t gives out_valid at t+1.
  - Otherwise one instruction issued per cycle while out_ready stays 1.
- Per-warp program order is preserved. Warps are interleaved round-robin; a warp cannot issue twice in a row while another warp is nonempty.
- Simultaneous enqueue and pop on the same warp: count unchanged, both pointers advance.
- Full warp with pop and enqueue in the same cycle: enqueue is refused (dec_ready=0).
- Round-robin pointer updates only on a slot load (including bypass).

Optional Feature:
- Macro: IBUF_PERF_EN.
- Defined: perf_stalls increments every cycle with out_valid & ~out_ready, saturating at 32'hFFFFFFFF, and resets to 0.
- Undefined: no counter logic; perf_stalls is tied to 0.

Test Plan:
- Reset, then a single enqueue (wid=2, rd=5, pc=0x80000000) with out_ready=1 → out_valid=1 the next cycle with out_wid=2, out_rd=5; out_wid_n=2 and out_rd_n=5 one cycle earlier.
- Fill warp 1 with 2 entries while out_ready=0 → dec_ready=0 for wid=1 while dec_ready=1 for wid=0; a third push to warp 1 is dropped and the FIFO is unchanged.
- Load warps 0, 1, 3 with 2 entries each, then hold out_ready=1 → issue order of wids is 0,1,3,0,1,3; PCs are in per-warp order.
- Hold out_ready=0 for 5 cycles with out_valid=1 → outputs stable and *_n equal to out_*; with IBUF_PERF_EN, perf_stalls=5.
- Over random traffic, check every cycle that out_* (t+1) == *_n (t) and that no instruction is lost or duplicated (uuid scoreboard).
- Assert reset mid-stream with 3 entries queued → on the next cycle out_valid=0, dec_ready=0; after release, the first enqueue appears with 1-cycle latency.
